alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; all state updates on it.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 req_valid  in  1  request present; req_ready  out  1  block can accept a request.
REQ-004 req_aluop  in  2  00=add, 01=sub/branch, 10=decode funct, 11=illegal; req_funct  in  6  R-type funct field.
REQ-005 req_a, req_b  in  32 each  operands.
REQ-006 alu_a, alu_b  out  32 each; alu_f  out  4  drive the downstream combinational ALU.
REQ-007 alu_y  in  32  ALU result; alu_zero  in  4  ALU zero flag, only bit 0 meaningful, bits 3:1 ignored.
REQ-008 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-009 rsp_y  out  32  result; rsp_zero  out  1  captured zero; rsp_err  out  1  illegal operation.
REQ-010 op_count  out  16  completed-response counter.

Function
REQ-011 alu_f codes SHALL be: AND=1, ADD=2, OR=3, SUB=6, SLT=7, NOP=0.
REQ-012 Decode: aluop 00->ADD; 01->SUB; 10 with funct 100000->ADD, 100010->SUB, 100100->AND, 100101->OR, 101010->SLT; any other funct or aluop 11 -> illegal.
REQ-013 FSM states IDLE, ISSUE, RESP.
REQ-014 IDLE: req_ready=1; on req_valid, latch a, b, decoded f, illegal flag; legal->ISSUE, illegal->RESP.
REQ-015 ISSUE (exactly one cycle): alu_a/alu_b/alu_f driven from latched registers; alu_y and alu_zero[0] captured into rsp_y/rsp_zero at end of cycle; ->RESP.
REQ-016 RESP: rsp_valid=1; rsp_y/rsp_zero/rsp_err stable until rsp_valid&&rsp_ready; then ->IDLE.
REQ-017 Illegal op: rsp_y=0, rsp_zero=1, rsp_err=1; ALU not issued; alu_f stays 0.
REQ-018 Latency: request accepted in cycle N -> rsp_valid in N+2 (legal) or N+1 (illegal).
REQ-019 req_ready SHALL be 0 in ISSUE and RESP; no new request accepted in the completion cycle of a response (one bubble cycle in IDLE minimum).
REQ-020 Outside ISSUE, alu_f SHALL be 0 and alu_a/alu_b SHALL hold last latched values.
REQ-021 op_count SHALL increment by 1 on each rsp handshake, legal or illegal, wrapping 0xFFFF->0x0000.
REQ-022 rsp_valid SHALL NOT drop before handshake, regardless of req_valid.

Reset
REQ-023 reset SHALL asynchronously force state IDLE; req_ready=1 after release, rsp_valid=0, rsp_y=0, rsp_zero=0, rsp_err=0, alu_a=0, alu_b=0, alu_f=0, op_count=0.
REQ-024 Reset asserted mid-operation SHALL discard the in-flight request with no response and no count increment.

Structure
REQ-025 Shared package alu_pkg SHALL hold the alu_f code constants, aluop encodings, funct constants, and FSM state typedef.
REQ-026 Decode SHALL be a separate combinational sub-module alu_dec (aluop, funct -> f, illegal); the ALU itself is instantiated outside this block.

Verification
REQ-027 aluop=10, funct=100010, a=5, b=5, rsp_ready=1 -> alu_f=6 in ISSUE; rsp_y=0, rsp_zero=1, rsp_err=0 at N+2.
REQ-028 aluop=10, funct=101010, a=0xFFFFFFFF, b=1 -> alu_f=7; rsp_y=1, rsp_zero=0.
REQ-029 aluop=10, funct=000000 -> rsp_valid at N+1, rsp_err=1, rsp_y=0, alu_f never nonzero.
REQ-030 aluop=00, a=7, b=9, rsp_ready held 0 for 5 cycles -> rsp_valid held, rsp_y=16 stable, req_ready=0; handshake then op_count+1.
REQ-031 reset pulsed during ISSUE -> rsp_valid=0, op_count unchanged (0), req_ready=1 after release.
REQ-032 op_count preset by 65535 handshakes, one more -> op_count=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU function codes,
// aluop/funct encodings and the controller state type.
package alu_pkg;

   localparam logic [3:0] ALU_F_NOP = 4'd0;
   localparam logic [3:0] ALU_F_AND = 4'd1;
   localparam logic [3:0] ALU_F_ADD = 4'd2;
   localparam logic [3:0] ALU_F_OR  = 4'd3;
   localparam logic [3:0] ALU_F_SUB = 4'd6;
   localparam logic [3:0] ALU_F_SLT = 4'd7;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_ILL   = 2'b11;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RESP
   } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, downstream-ALU and response signals of the ALU issue controller.
// The controller uses the slave view; its environment uses the master view.
interface alu_issue_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_aluop;
   logic [5:0]  req_funct;
   logic [31:0] req_a;
   logic [31:0] req_b;

   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_f;
   logic [31:0] alu_y;
   logic [3:0]  alu_zero;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_y;
   logic        rsp_zero;
   logic        rsp_err;

   modport slave (
      input  req_valid, req_aluop, req_funct, req_a, req_b,
      output req_ready,
      output alu_a, alu_b, alu_f,
      input  alu_y, alu_zero,
      output rsp_valid, rsp_y, rsp_zero, rsp_err,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_aluop, req_funct, req_a, req_b,
      input  req_ready,
      input  alu_a, alu_b, alu_f,
      output alu_y, alu_zero,
      input  rsp_valid, rsp_y, rsp_zero, rsp_err,
      output rsp_ready
   );

endinterface

// File: rtl/alu_dec.sv
// Combinational ALU control decode: aluop/funct to ALU function code,
// flagging encodings the ALU cannot execute.
module alu_dec
   import alu_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [3:0] f,
   output logic       illegal
);

   always_comb begin
      f       = ALU_F_NOP;
      illegal = 1'b0;
      case (aluop)
         ALUOP_ADD: f = ALU_F_ADD;
         ALUOP_SUB: f = ALU_F_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_ADD: f = ALU_F_ADD;
               FUNCT_SUB: f = ALU_F_SUB;
               FUNCT_AND: f = ALU_F_AND;
               FUNCT_OR:  f = ALU_F_OR;
               FUNCT_SLT: f = ALU_F_SLT;
               default:   illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded request at a time to an external combinational ALU and
// returns the captured result over a valid/ready response handshake.
module alu_issue_ctrl
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   alu_issue_ctrl_if.slave bus,
   output logic [15:0]     op_count
);

   state_t      state;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] rsp_y_q;
   logic [3:0]  alu_f_q;
   logic [3:0]  dec_f;
   logic        dec_illegal;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic        rsp_zero_q;
   logic        rsp_err_q;
   logic        unused_zero_bits;

   alu_dec u_dec (
      .aluop   (bus.req_aluop),
      .funct   (bus.req_funct),
      .f       (dec_f),
      .illegal (dec_illegal)
   );

   assign bus.req_ready = req_ready_q;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_f     = alu_f_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_y     = rsp_y_q;
   assign bus.rsp_zero  = rsp_zero_q;
   assign bus.rsp_err   = rsp_err_q;

   // Only bit 0 of the ALU zero bus carries information.
   assign unused_zero_bits = ^bus.alu_zero[3:1];

   // alu_f is nonzero only while in ISSUE; illegal requests skip ISSUE entirely.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_y_q     <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         alu_f_q     <= ALU_F_NOP;
         op_count    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  a_q         <= bus.req_a;
                  b_q         <= bus.req_b;
                  req_ready_q <= 1'b0;
                  if (dec_illegal) begin
                     rsp_y_q     <= '0;
                     rsp_zero_q  <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state       <= ST_RESP;
                  end else begin
                     alu_f_q   <= dec_f;
                     rsp_err_q <= 1'b0;
                     state     <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               rsp_y_q     <= bus.alu_y;
               rsp_zero_q  <= bus.alu_zero[0];
               rsp_valid_q <= 1'b1;
               alu_f_q     <= ALU_F_NOP;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  op_count    <= op_count + 16'd1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state       <= ST_IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               alu_f_q     <= ALU_F_NOP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural ALU sits downstream and
// a scoreboard of reference results is checked against each response.
module tb_alu_issue_ctrl;

   typedef struct packed {
      logic [31:0] y;
      logic        zero;
      logic        err;
      logic [3:0]  f;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] op_count;
   logic [31:0] mock_y;
   logic [15:0] exp_count = '0;
   int          n_cmp = 0;
   int          n_fail = 0;
   exp_t        sb[$];

   alu_issue_ctrl_if bus ();

   alu_issue_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   // Downstream ALU; the upper zero bits are deliberately junk.
   always_comb begin
      mock_y = '0;
      case (bus.alu_f)
         4'd1: mock_y = bus.alu_a & bus.alu_b;
         4'd2: mock_y = bus.alu_a + bus.alu_b;
         4'd3: mock_y = bus.alu_a | bus.alu_b;
         4'd6: mock_y = bus.alu_a - bus.alu_b;
         4'd7: mock_y = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
         default: mock_y = '0;
      endcase
   end
   assign bus.alu_y    = mock_y;
   assign bus.alu_zero = {3'b101, mock_y == 32'd0};

   function automatic exp_t ref_op(input logic [1:0] aluop, input logic [5:0] funct,
                                   input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic ok;
      ok  = 1'b1;
      e.f = 4'd0;
      e.y = '0;
      if (aluop == 2'b00) begin
         e.f = 4'd2; e.y = a + b;
      end else if (aluop == 2'b01) begin
         e.f = 4'd6; e.y = a - b;
      end else if (aluop == 2'b10 && funct == 6'h20) begin
         e.f = 4'd2; e.y = a + b;
      end else if (aluop == 2'b10 && funct == 6'h22) begin
         e.f = 4'd6; e.y = a - b;
      end else if (aluop == 2'b10 && funct == 6'h24) begin
         e.f = 4'd1; e.y = a & b;
      end else if (aluop == 2'b10 && funct == 6'h25) begin
         e.f = 4'd3; e.y = a | b;
      end else if (aluop == 2'b10 && funct == 6'h2a) begin
         e.f = 4'd7; e.y = {31'd0, $signed(a) < $signed(b)};
      end else begin
         ok = 1'b0;
      end
      e.err  = ~ok;
      e.zero = ok ? (e.y == 32'd0) : 1'b1;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue_req(input logic [1:0] aluop, input logic [5:0] funct,
                            input logic [31:0] a, input logic [31:0] b);
      int w;
      w = 0;
      while (!bus.req_ready && w < 20) begin
         step();
         w++;
      end
      if (w >= 20) begin
         n_cmp++; n_fail++;
         $display("[TB] FAIL req_ready_timeout: req_ready=%0b required=1", bus.req_ready);
      end
      bus.req_aluop = aluop;
      bus.req_funct = funct;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_valid = 1'b1;
      sb.push_back(ref_op(aluop, funct, a, b));
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic handshake();
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      exp_count = exp_count + 16'd1;
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_y, bus.rsp_zero, bus.rsp_err} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL reset_handshake: rdy=%0b vld=%0b y=%h z=%0b e=%0b required 1 0 0 0 0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_y, bus.rsp_zero, bus.rsp_err);
      end
      n_cmp++;
      if ({bus.alu_a, bus.alu_b, bus.alu_f, op_count} !== {32'd0, 32'd0, 4'd0, 16'd0}) begin
         n_fail++;
         $display("[TB] FAIL reset_alu_count: a=%h b=%h f=%0d cnt=%0d required all 0",
                  bus.alu_a, bus.alu_b, bus.alu_f, op_count);
      end
   endtask

   task automatic test_legal_op(input logic [1:0] aluop, input logic [5:0] funct,
                                input logic [31:0] a, input logic [31:0] b, input string name);
      exp_t e;
      int   lat;
      issue_req(aluop, funct, a, b);
      e = sb[$];
      n_cmp++;
      if ({bus.alu_f, bus.alu_a, bus.alu_b, bus.req_ready, bus.rsp_valid} !== {e.f, a, b, 1'b0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL %s_issue: f=%0d a=%h b=%h rdy=%0b vld=%0b required f=%0d a=%h b=%h 0 0",
                  name, bus.alu_f, bus.alu_a, bus.alu_b, bus.req_ready, bus.rsp_valid, e.f, a, b);
      end
      wait_rsp(lat);
      n_cmp++;
      if (lat != 2) begin
         n_fail++;
         $display("[TB] FAIL %s_latency: got %0d required 2", name, lat);
      end
      e = sb.pop_front();
      n_cmp++;
      if ({bus.rsp_y, bus.rsp_zero, bus.rsp_err} !== {e.y, e.zero, e.err}) begin
         n_fail++;
         $display("[TB] FAIL %s_result: y=%h z=%0b e=%0b required y=%h z=%0b e=%0b",
                  name, bus.rsp_y, bus.rsp_zero, bus.rsp_err, e.y, e.zero, e.err);
      end
      handshake();
      n_cmp++;
      if ({op_count, bus.rsp_valid, bus.req_ready, bus.alu_f, bus.alu_a, bus.alu_b} !== {exp_count, 1'b0, 1'b1, 4'd0, a, b}) begin
         n_fail++;
         $display("[TB] FAIL %s_done: cnt=%0d vld=%0b rdy=%0b f=%0d a=%h b=%h required cnt=%0d 0 1 0 a=%h b=%h",
                  name, op_count, bus.rsp_valid, bus.req_ready, bus.alu_f, bus.alu_a, bus.alu_b, exp_count, a, b);
      end
   endtask

   task automatic test_illegal_op(input logic [1:0] aluop, input logic [5:0] funct,
                                  input logic [31:0] a, input logic [31:0] b, input string name);
      exp_t e;
      issue_req(aluop, funct, a, b);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.rsp_valid, bus.alu_f, bus.req_ready} !== {1'b1, 4'd0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL %s_latency: vld=%0b f=%0d rdy=%0b required 1 0 0",
                  name, bus.rsp_valid, bus.alu_f, bus.req_ready);
      end
      n_cmp++;
      if ({bus.rsp_y, bus.rsp_zero, bus.rsp_err} !== {e.y, e.zero, e.err}) begin
         n_fail++;
         $display("[TB] FAIL %s_result: y=%h z=%0b e=%0b required y=%h z=%0b e=%0b",
                  name, bus.rsp_y, bus.rsp_zero, bus.rsp_err, e.y, e.zero, e.err);
      end
      handshake();
      n_cmp++;
      if ({op_count, bus.rsp_valid, bus.alu_f} !== {exp_count, 1'b0, 4'd0}) begin
         n_fail++;
         $display("[TB] FAIL %s_done: cnt=%0d vld=%0b f=%0d required cnt=%0d 0 0",
                  name, op_count, bus.rsp_valid, bus.alu_f, exp_count);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      issue_req(2'b00, 6'd0, 32'd3, 32'd4);
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if ({bus.rsp_valid, bus.alu_f, bus.req_ready} !== {1'b0, 4'd0, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_async: vld=%0b f=%0d rdy=%0b required 0 0 1",
                  bus.rsp_valid, bus.alu_f, bus.req_ready);
      end
      #1 reset = 1'b0;
      void'(sb.pop_back());
      exp_count = '0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.rsp_valid) seen++;
      end
      n_cmp++;
      if ({seen, op_count, bus.req_ready} !== {32'd0, 16'd0, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL reset_mid_after: rsp_cycles=%0d cnt=%0d rdy=%0b required 0 0 1",
                  seen, op_count, bus.req_ready);
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   lat;
      issue_req(2'b00, 6'd0, 32'd7, 32'd9);
      wait_rsp(lat);
      e = sb.pop_front();
      bus.req_aluop = 2'b00;
      bus.req_a     = 32'd1;
      bus.req_b     = 32'd2;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({bus.rsp_valid, bus.rsp_y, bus.req_ready} !== {1'b1, e.y, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL backpressure_hold%0d: vld=%0b y=%0d rdy=%0b required 1 %0d 0",
                     i, bus.rsp_valid, bus.rsp_y, bus.req_ready, e.y);
         end
         step();
      end
      handshake();
      n_cmp++;
      if ({bus.rsp_valid, bus.req_ready, bus.alu_f, op_count} !== {1'b0, 1'b1, 4'd0, exp_count}) begin
         n_fail++;
         $display("[TB] FAIL backpressure_bubble: vld=%0b rdy=%0b f=%0d cnt=%0d required 0 1 0 %0d",
                  bus.rsp_valid, bus.req_ready, bus.alu_f, op_count, exp_count);
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [5:0]  functs [8];
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;
      functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h3f, 6'h21};
      for (int i = 0; i < 14; i++) begin
         op = 2'($urandom_range(0, 3));
         fn = functs[$urandom_range(0, 7)];
         a  = (i % 4 == 0) ? 32'd0 : $urandom;
         b  = (i % 3 == 0) ? a : $urandom;
         e  = ref_op(op, fn, a, b);
         if (e.err) test_illegal_op(op, fn, a, b, "b2b_illegal");
         else       test_legal_op(op, fn, a, b, "b2b_legal");
      end
   endtask

   task automatic test_wrap();
      force dut.op_count = 16'hFFFE;
      #1 release dut.op_count;
      exp_count = 16'hFFFE;
      test_illegal_op(2'b11, 6'h20, 32'd1, 32'd1, "wrap_ffff");
      test_illegal_op(2'b11, 6'h20, 32'd2, 32'd2, "wrap_zero");
      n_cmp++;
      if (op_count !== 16'h0000) begin
         n_fail++;
         $display("[TB] FAIL wrap_final: cnt=%h required 0000", op_count);
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_aluop = 2'b00;
      bus.req_funct = 6'd0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_reset_mid();
      test_legal_op(2'b10, 6'b100010, 32'd5, 32'd5, "sub_zero");
      test_legal_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, "slt_signed");
      test_legal_op(2'b01, 6'd0, 32'd3, 32'd10, "aluop_sub");
      test_legal_op(2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FFFF, "and");
      test_legal_op(2'b10, 6'b100101, 32'hF000_0000, 32'h0000_000F, "or");
      test_illegal_op(2'b10, 6'b000000, 32'd8, 32'd9, "funct_illegal");
      test_illegal_op(2'b11, 6'b100000, 32'd8, 32'd9, "aluop_illegal");
      test_backpressure();
      test_back_to_back();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
